inst_decode_queue: RTL and testbench
====================================

// Module: inst_decode_queue
// PURPOSE
//  Instruction buffer between fetch and dispatch. Decodes each RV32I word on enqueue and
//  stores decoded fields, PC and prediction bit in a DEPTH-entry circular FIFO. Presents the
//  head entry to dispatch with a valid/ready handshake. Adds illegal-opcode detection,
//  register-use flags and full sign extension. Flushes on branch mispredict.
// PARAMETERS
//  XLEN      32  data, PC and immediate width (XLEN >= 32)
//  DEPTH     8   FIFO entries; power of two, >= 2
//  REG_IDX_W 5   architectural register index width
// PORTS
//  clk_in        in   1              clock; all state updates on the rising edge
//  rst_n_in      in   1              asynchronous, active-low reset
//  flush_in      in   1              discard all entries (mispredict/exception)
//  in_valid      in   1              fetch is offering an instruction
//  in_ready      out  1              queue can accept an instruction
//  in_inst       in   32             raw instruction word
//  in_pc         in   XLEN           PC of in_inst
//  in_pred_taken in   1              predictor decision for in_inst
//  out_valid     out  1              head entry is valid
//  out_ready     in   1              dispatch accepts the head entry
//  out_type      out  INST_TYPE_W    decoded operation code, from the shared constants
//  out_rd        out  REG_IDX_W      destination index (inst[11:7])
//  out_rs1       out  REG_IDX_W      source 1 index (inst[19:15])
//  out_rs2       out  REG_IDX_W      source 2 index (inst[24:20])
//  out_imm       out  XLEN           sign-extended immediate; 0 for R-type
//  out_wr_rd     out  1              writes rd; forced 0 when rd == x0
//  out_use_rs1   out  1              reads rs1
//  out_use_rs2   out  1              reads rs2
//  out_illegal   out  1              unsupported encoding; out_type = ILLEGAL
//  out_pc        out  XLEN           PC of the head entry
//  out_pred      out  1              prediction bit of the head entry
// BEHAVIOUR
//  - Reset (rst_n_in low, asynchronous): head, tail and count go to 0.
//    in_ready goes to 1, out_valid goes to 0, and all out_* data outputs go to 0.
//  - push = in_valid & in_ready. pop = out_valid & out_ready.
//  - in_ready = (count != DEPTH). out_valid = (count != 0). Both are derived from registered
//    count and have no combinational path from in_valid or out_ready.
//  - Push writes the decoded fields into the entry at tail, then advances tail by 1 mod DEPTH.
//    Pop advances head by 1 mod DEPTH. Pointers wrap naturally with log2(DEPTH) bits.
//  - The count register is $clog2(DEPTH+1) bits wide.
//    push & pop in the same cycle: count is unchanged; legal at any occupancy below full.
//  - Latency: an entry pushed in cycle N is visible on out_* in cycle N+1 when the queue
//    was empty. There is no bypass.
//  - out_* fields are read combinationally from the head entry's registers.
//    They are stable while out_valid=1 and out_ready=0.
//  - flush_in has priority over push and pop in the same cycle.
//    Next cycle: count=0 and head=tail=0. Any push in the flush cycle is dropped.
//  - Decode rules:
//    U-type imm = {inst[31:12], 12'b0}.
//    I, S, B and J immediates are sign-extended from their top bit to XLEN.
//    SLLI, SRLI and SRAI: imm = zero-extended inst[24:20].
//    JAL, JALR and LUI/AUIPC set wr_rd. Branches and stores set use_rs1 and use_rs2.
//  - Illegal: any of the following sets out_illegal=1, out_type=ILLEGAL and clears wr_rd,
//    use_rs1 and use_rs2:
//    - an unknown opcode
//    - funct3 values 3'h2/3'h3 on branches, or >2 on stores
//    - funct3 values 3/6/7 on loads
//    - funct7 other than 0x00/0x20 on ADD/SUB/SRL/SRA
//    - funct7 other than 0x00 on the remaining R-type ops
//    - inst[1:0] != 2'b11
//    Illegal entries are still queued and popped in order.
//  - Reset mid-operation clears all state immediately. Stored contents are don't-care
//    afterwards, but out_valid stays 0.
// STRUCTURE
//  - Shared constants header holds INST_TYPE_W, the operation codes, the ILLEGAL code and
//    the opcode/funct constants. The dispatch and ALU blocks include the same header.
//  - One sub-module, rv32i_decode_core: purely combinational inst -> {type, rd, rs1, rs2, imm,
//    flags, illegal}, instantiated once on the push path.
//  - FIFO storage: one register array per field, or a packed entry vector; no memory macro.
// TESTING
//  - ADDI x1,x0,-1 (0xFFF00093) pushed into an empty queue:
//    next cycle out_valid=1, type=ADDI, rd=1, imm=0xFFFFFFFF, wr_rd=1, use_rs1=1, use_rs2=0.
//  - Push 8 instructions with out_ready=0: in_ready=0 after the 8th push.
//    A 9th in_valid is ignored. Pops then return PCs in order with no loss.
//  - Push and pop every cycle for 20 cycles at count=3: count stays 3, the PC sequence is
//    monotonic and the pointers wrap cleanly.
//  - flush_in together with in_valid at count=5: next cycle out_valid=0 and in_ready=1.
//    The flushed instruction never appears at the output.
//  - BEQ with imm -4 (0xFE000EE3): imm=0xFFFFFFFC, use_rs1=1, use_rs2=1, wr_rd=0.
//    Word 0x0000007F: out_illegal=1, type=ILLEGAL.
//  - Assert rst_n_in mid-stream at count=4: out_valid drops asynchronously.
//    After release, in_ready=1 and count=0.

Source files
------------

// File: rtl/inst_decode_queue_pkg.sv
// Shared constants for the instruction buffer: operation codes, opcode and funct values.
// The dispatch and ALU blocks import this same package.
package inst_decode_queue_pkg;

  localparam int INST_TYPE_W = 6;

  // Code 0 is ILLEGAL so an idle (all-zero) output bus never names a real operation
  typedef enum logic [INST_TYPE_W-1:0] {
    ILLEGAL = 6'd0,
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
  } inst_type_e;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

endpackage

// File: rtl/inst_decode_queue_decode_core.sv
// Combinational RV32I decoder: raw word to operation code, register fields,
// sign-extended immediate, register-use flags and illegal flag.
module rv32i_decode_core
  import inst_decode_queue_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic [31:0]          inst,
  output inst_type_e           itype,
  output logic [REG_IDX_W-1:0] rd,
  output logic [REG_IDX_W-1:0] rs1,
  output logic [REG_IDX_W-1:0] rs2,
  output logic [XLEN-1:0]      imm,
  output logic                 wr_rd,
  output logic                 use_rs1,
  output logic                 use_rs2,
  output logic                 illegal
);

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;
  inst_type_e t;
  logic w, u1, u2;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];
  assign rd  = REG_IDX_W'(inst[11:7]);
  assign rs1 = REG_IDX_W'(inst[19:15]);
  assign rs2 = REG_IDX_W'(inst[24:20]);

  assign imm_i  = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_s  = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j  = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_u  = XLEN'({inst[31:12], 12'b0});
  assign imm_sh = XLEN'(inst[24:20]);

  // Opcode bits [1:0] are part of every constant, so a non-32-bit word never matches
  always_comb begin
    t   = ILLEGAL;
    imm = '0;
    w   = 1'b0;
    u1  = 1'b0;
    u2  = 1'b0;
    unique case (opc)
      OPC_LUI:   begin t = LUI;   imm = imm_u; w = 1'b1; end
      OPC_AUIPC: begin t = AUIPC; imm = imm_u; w = 1'b1; end
      OPC_JAL:   begin t = JAL;   imm = imm_j; w = 1'b1; end
      OPC_JALR:  begin t = JALR;  imm = imm_i; w = 1'b1; u1 = 1'b1; end
      OPC_BRANCH: begin
        imm = imm_b; u1 = 1'b1; u2 = 1'b1;
        case (f3)
          3'd0: t = BEQ;  3'd1: t = BNE;
          3'd4: t = BLT;  3'd5: t = BGE;
          3'd6: t = BLTU; 3'd7: t = BGEU;
          default: t = ILLEGAL;
        endcase
      end
      OPC_LOAD: begin
        imm = imm_i; w = 1'b1; u1 = 1'b1;
        case (f3)
          3'd0: t = LB;  3'd1: t = LH; 3'd2: t = LW;
          3'd4: t = LBU; 3'd5: t = LHU;
          default: t = ILLEGAL;
        endcase
      end
      OPC_STORE: begin
        imm = imm_s; u1 = 1'b1; u2 = 1'b1;
        case (f3)
          3'd0: t = SB; 3'd1: t = SH; 3'd2: t = SW;
          default: t = ILLEGAL;
        endcase
      end
      OPC_OPIMM: begin
        imm = imm_i; w = 1'b1; u1 = 1'b1;
        case (f3)
          3'd0: t = ADDI;  3'd2: t = SLTI;
          3'd3: t = SLTIU; 3'd4: t = XORI;
          3'd6: t = ORI;   3'd7: t = ANDI;
          3'd1: begin t = SLLI; imm = imm_sh; end
          default: begin t = inst[30] ? SRAI : SRLI; imm = imm_sh; end
        endcase
      end
      OPC_OP: begin
        w = 1'b1; u1 = 1'b1; u2 = 1'b1;
        if (f7 == F7_BASE) begin
          case (f3)
            3'd0: t = ADD; 3'd1: t = SLL; 3'd2: t = SLT;  3'd3: t = SLTU;
            3'd4: t = XOR; 3'd5: t = SRL; 3'd6: t = OR;   default: t = AND;
          endcase
        end else if (f7 == F7_ALT && f3 == 3'd0) begin
          t = SUB;
        end else if (f7 == F7_ALT && f3 == 3'd5) begin
          t = SRA;
        end else begin
          t = ILLEGAL;
        end
      end
      default: t = ILLEGAL;
    endcase
  end

  assign itype   = t;
  assign illegal = (t == ILLEGAL);
  assign wr_rd   = w & ~illegal & (inst[11:7] != 5'd0);
  assign use_rs1 = u1 & ~illegal;
  assign use_rs2 = u2 & ~illegal;

endmodule

// File: rtl/inst_decode_queue.sv
// Fetch-to-dispatch instruction buffer: decodes on enqueue and holds decoded entries
// in a DEPTH-entry circular FIFO with valid/ready handshakes on both sides.
module inst_decode_queue
  import inst_decode_queue_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 8,
  parameter int REG_IDX_W = 5
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   flush_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_inst,
  input  logic [XLEN-1:0]        in_pc,
  input  logic                   in_pred_taken,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INST_TYPE_W-1:0] out_type,
  output logic [REG_IDX_W-1:0]   out_rd,
  output logic [REG_IDX_W-1:0]   out_rs1,
  output logic [REG_IDX_W-1:0]   out_rs2,
  output logic [XLEN-1:0]        out_imm,
  output logic                   out_wr_rd,
  output logic                   out_use_rs1,
  output logic                   out_use_rs2,
  output logic                   out_illegal,
  output logic [XLEN-1:0]        out_pc,
  output logic                   out_pred
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic push, pop;

  inst_type_e           d_type;
  logic [REG_IDX_W-1:0] d_rd, d_rs1, d_rs2;
  logic [XLEN-1:0]      d_imm;
  logic                 d_wr, d_u1, d_u2, d_ill;

  inst_type_e           q_type  [DEPTH];
  logic [REG_IDX_W-1:0] q_rd    [DEPTH];
  logic [REG_IDX_W-1:0] q_rs1   [DEPTH];
  logic [REG_IDX_W-1:0] q_rs2   [DEPTH];
  logic [XLEN-1:0]      q_imm   [DEPTH];
  logic [3:0]           q_flags [DEPTH];
  logic [XLEN-1:0]      q_pc    [DEPTH];
  logic                 q_pred  [DEPTH];

  rv32i_decode_core #(.XLEN(XLEN), .REG_IDX_W(REG_IDX_W)) u_decode (
    .inst    (in_inst),
    .itype   (d_type),
    .rd      (d_rd),
    .rs1     (d_rs1),
    .rs2     (d_rs2),
    .imm     (d_imm),
    .wr_rd   (d_wr),
    .use_rs1 (d_u1),
    .use_rs2 (d_u2),
    .illegal (d_ill)
  );

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: out_valid masks whatever it holds
  always_ff @(posedge clk_in) begin
    if (push && !flush_in) begin
      q_type[tail]  <= d_type;
      q_rd[tail]    <= d_rd;
      q_rs1[tail]   <= d_rs1;
      q_rs2[tail]   <= d_rs2;
      q_imm[tail]   <= d_imm;
      q_flags[tail] <= {d_wr, d_u1, d_u2, d_ill};
      q_pc[tail]    <= in_pc;
      q_pred[tail]  <= in_pred_taken;
    end
  end

  assign out_type    = out_valid ? q_type[head]     : '0;
  assign out_rd      = out_valid ? q_rd[head]       : '0;
  assign out_rs1     = out_valid ? q_rs1[head]      : '0;
  assign out_rs2     = out_valid ? q_rs2[head]      : '0;
  assign out_imm     = out_valid ? q_imm[head]      : '0;
  assign out_wr_rd   = out_valid & q_flags[head][3];
  assign out_use_rs1 = out_valid & q_flags[head][2];
  assign out_use_rs2 = out_valid & q_flags[head][1];
  assign out_illegal = out_valid & q_flags[head][0];
  assign out_pc      = out_valid ? q_pc[head]       : '0;
  assign out_pred    = out_valid & q_pred[head];

endmodule

// File: tb/tb_inst_decode_queue.sv
// Directed and randomized bench for inst_decode_queue against a queue-based
// reference model whose decoder is table-driven from the RV32I field rules.
module tb_inst_decode_queue;
  import inst_decode_queue_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int RW    = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, in_pred = 1'b0;
  logic [31:0] in_inst = '0, in_pc = '0;
  logic in_ready, out_valid, out_wr_rd, out_use_rs1, out_use_rs2, out_illegal, out_pred;
  logic [INST_TYPE_W-1:0] out_type;
  logic [RW-1:0] out_rd, out_rs1, out_rs2;
  logic [XLEN-1:0] out_imm, out_pc;

  always #5 clk = ~clk;

  inst_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .REG_IDX_W(RW)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .in_pred_taken(in_pred), .out_valid(out_valid), .out_ready(out_ready),
    .out_type(out_type), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_wr_rd(out_wr_rd), .out_use_rs1(out_use_rs1),
    .out_use_rs2(out_use_rs2), .out_illegal(out_illegal), .out_pc(out_pc),
    .out_pred(out_pred)
  );

  typedef struct {
    inst_type_e  typ;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        wr, u1, u2, ill;
    logic [31:0] pc;
    logic        pred;
  } exp_t;

  localparam inst_type_e BR_T  [8] = '{BEQ, BNE, ILLEGAL, ILLEGAL, BLT, BGE, BLTU, BGEU};
  localparam inst_type_e LD_T  [8] = '{LB, LH, LW, ILLEGAL, LBU, LHU, ILLEGAL, ILLEGAL};
  localparam inst_type_e ST_T  [8] = '{SB, SH, SW, ILLEGAL, ILLEGAL, ILLEGAL, ILLEGAL, ILLEGAL};
  localparam inst_type_e IMM_T [8] = '{ADDI, SLLI, SLTI, SLTIU, XORI, SRLI, ORI, ANDI};
  localparam inst_type_e R0_T  [8] = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
  localparam logic [6:0] OPS [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

  int checks = 0;
  int errors = 0;
  exp_t mq[$];
  logic [31:0] pcNext = 32'h0000_1000;
  logic [31:0] prevPc;

  function automatic exp_t modelDecode(input logic [31:0] w, input logic [31:0] pc, input logic pred);
    exp_t e;
    int si = $signed(w);
    int f3 = int'(w[14:12]);
    e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    e.pc = pc; e.pred = pred;
    e.imm = '0; e.wr = 0; e.u1 = 0; e.u2 = 0; e.typ = ILLEGAL;
    case (w[6:0])
      7'h37: begin e.typ = LUI;   e.imm = w & 32'hFFFF_F000; e.wr = 1; end
      7'h17: begin e.typ = AUIPC; e.imm = w & 32'hFFFF_F000; e.wr = 1; end
      7'h6F: begin
        e.typ = JAL; e.wr = 1;
        e.imm = ((si >>> 31) <<< 20) | (int'(w[19:12]) << 12) | (int'(w[20]) << 11) | (int'(w[30:21]) << 1);
      end
      7'h67: begin e.typ = JALR; e.imm = si >>> 20; e.wr = 1; e.u1 = 1; end
      7'h63: begin
        e.typ = BR_T[f3]; e.u1 = 1; e.u2 = 1;
        e.imm = ((si >>> 31) <<< 12) | (int'(w[7]) << 11) | (int'(w[30:25]) << 5) | (int'(w[11:8]) << 1);
      end
      7'h03: begin e.typ = LD_T[f3]; e.imm = si >>> 20; e.wr = 1; e.u1 = 1; end
      7'h23: begin
        e.typ = ST_T[f3]; e.u1 = 1; e.u2 = 1;
        e.imm = ((si >>> 25) <<< 5) | int'(w[11:7]);
      end
      7'h13: begin
        e.typ = (f3 == 5 && w[30]) ? SRAI : IMM_T[f3];
        e.imm = (f3 == 1 || f3 == 5) ? 32'(w[24:20]) : 32'(si >>> 20);
        e.wr = 1; e.u1 = 1;
      end
      7'h33: begin
        e.wr = 1; e.u1 = 1; e.u2 = 1;
        if (w[31:25] == 7'h00)                    e.typ = R0_T[f3];
        else if (w[31:25] == 7'h20 && f3 == 0)    e.typ = SUB;
        else if (w[31:25] == 7'h20 && f3 == 5)    e.typ = SRA;
      end
      default: e.typ = ILLEGAL;
    endcase
    e.ill = (e.typ == ILLEGAL);
    if (e.ill) begin e.wr = 0; e.u1 = 0; e.u2 = 0; end
    if (e.rd == 0) e.wr = 0;
    return e;
  endfunction

  function automatic logic [31:0] randInst();
    logic [31:0] w = $urandom;
    if ($urandom_range(0, 9) < 8) begin
      w[6:0] = OPS[$urandom_range(0, 8)];
      if (w[6:0] == 7'h33 && $urandom_range(0, 3) != 0)
        w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    end
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    chk("out_valid", out_valid, mq.size() != 0);
    chk("in_ready", in_ready, mq.size() != DEPTH);
    if (mq.size() != 0) begin
      chk("type", out_type, mq[0].typ);
      chk("rd", out_rd, mq[0].rd);
      chk("rs1", out_rs1, mq[0].rs1);
      chk("rs2", out_rs2, mq[0].rs2);
      chk("imm", out_imm, mq[0].imm);
      chk("wr_rd", out_wr_rd, mq[0].wr);
      chk("use_rs1", out_use_rs1, mq[0].u1);
      chk("use_rs2", out_use_rs2, mq[0].u2);
      chk("illegal", out_illegal, mq[0].ill);
      chk("pc", out_pc, mq[0].pc);
      chk("pred", out_pred, mq[0].pred);
    end else begin
      chk("idle_type", out_type, 0);
      chk("idle_imm", out_imm, 0);
      chk("idle_pc", out_pc, 0);
    end
  endtask

  // Called at a falling edge: drive, check, clock once, advance the model
  task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic pred,
                               input logic ordy, input logic fl);
    logic doPush, doPop;
    in_valid = v; in_inst = inst; in_pc = pcNext; in_pred = pred;
    out_ready = ordy; flush = fl;
    checkOutput();
    doPush = v && (mq.size() < DEPTH);
    doPop  = ordy && (mq.size() > 0);
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (doPop) void'(mq.pop_front());
      if (doPush) mq.push_back(modelDecode(inst, pcNext, pred));
    end
    if (v) pcNext += 4;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && mq.size() != 0; i++) applyStimulus(0, 0, 0, 1, 0);
  endtask

  initial begin
    $display("[TB] start");
    #1 rst_n = 1'b0;
    #1 checkOutput();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ADDI x1,x0,-1 into an empty queue
    applyStimulus(1, 32'hFFF0_0093, 0, 0, 0);
    chk("addi_valid", out_valid, 1);
    chk("addi_type", out_type, ADDI);
    chk("addi_rd", out_rd, 1);
    chk("addi_imm", out_imm, 32'hFFFF_FFFF);
    chk("addi_wr", out_wr_rd, 1);
    chk("addi_rs1", out_use_rs1, 1);
    chk("addi_rs2", out_use_rs2, 0);
    drain();

    // Fill to full with dispatch stalled; 9th offer must be ignored
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, randInst(), i[0], 0, 0);
    chk("full_in_ready", in_ready, 0);
    applyStimulus(1, randInst(), 0, 0, 0);
    chk("full_hold", in_ready, 0);
    drain();
    chk("drained_valid", out_valid, 0);

    // Steady push+pop at occupancy 3
    for (int i = 0; i < 3; i++) applyStimulus(1, randInst(), 0, 0, 0);
    prevPc = mq[0].pc - 4;
    for (int i = 0; i < 20; i++) begin
      chk("steady_pc_order", out_pc > prevPc, 1);
      prevPc = out_pc;
      applyStimulus(1, randInst(), $urandom_range(0, 1), 1, 0);
    end
    drain();

    // Flush with a simultaneous push at occupancy 5
    for (int i = 0; i < 5; i++) applyStimulus(1, randInst(), 0, 0, 0);
    applyStimulus(1, randInst(), 0, 0, 1);
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    applyStimulus(1, 32'h0000_0013, 1, 0, 0);
    chk("after_flush_pc", out_pc, pcNext - 4);
    drain();

    // BEQ with imm -4, then an unknown opcode
    applyStimulus(1, 32'hFE00_0EE3, 0, 0, 0);
    applyStimulus(1, 32'h0000_007F, 0, 0, 0);
    chk("beq_type", out_type, BEQ);
    chk("beq_imm", out_imm, 32'hFFFF_FFFC);
    chk("beq_rs1", out_use_rs1, 1);
    chk("beq_rs2", out_use_rs2, 1);
    chk("beq_wr", out_wr_rd, 0);
    applyStimulus(0, 0, 0, 1, 0);
    chk("ill_flag", out_illegal, 1);
    chk("ill_type", out_type, ILLEGAL);
    drain();

    // Asynchronous reset at occupancy 4
    for (int i = 0; i < 4; i++) applyStimulus(1, randInst(), 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_valid", out_valid, 0);
    chk("async_ready", in_ready, 1);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 3) != 0, randInst(), $urandom_range(0, 1),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0);
    drain();
    checkOutput();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
